// File: rtl/letter_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : letter_entry_encoder
// Purpose  : Push-button letter selector (A=0..Z=25) with debounced UP/DOWN
//            scrolling and a valid/ready commit of the selection on ENTER.
//            Define AUTO_REPEAT_EN to add hold-to-repeat on UP/DOWN.
// Revision : 1.0 - initial release
// ============================================================================
module letter_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_ENTER,
    output logic [4:0] LET,
    output logic [4:0] LET_OUT,
    output logic       LET_VALID,
    input  logic       LET_READY,
    output logic       BUSY
);

    localparam int         c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [4:0] c_LET_MAX = 5'd25;
    localparam int         c_UP      = 0;
    localparam int         c_DN      = 1;
    localparam int         c_EN      = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [2:0] w_raw;
    logic [2:0] w_level;
    logic [2:0] w_press;
    logic       w_up;
    logic       w_dn;
    logic       w_unused;

    assign w_raw = {BTN_ENTER, BTN_DOWN, BTN_UP};

    // Per button: 2-flop synchronizer, debounce counter, rising-edge press pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic              r_meta;
            logic              r_sync;
            logic              r_level;
            logic              r_level_d;
            logic              r_press;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_meta    <= 1'b0;
                    r_sync    <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_press   <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_meta    <= w_raw[gi];
                    r_sync    <= r_meta;
                    r_level_d <= r_level;
                    r_press   <= r_level & ~r_level_d;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end
            end

            assign w_level[gi] = r_level;
            assign w_press[gi] = r_press;
        end
    endgenerate

`ifdef AUTO_REPEAT_EN
    localparam int c_RP_W = $clog2(REPEAT_DELAY + 1);

    logic [1:0] w_step;

    // Hold counter: after the first repeat it reloads so later repeats come
    // every REPEAT_PERIOD cycles (assumes REPEAT_PERIOD <= REPEAT_DELAY).
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            logic              w_only;
            logic [c_RP_W-1:0] r_hold;

            assign w_only = w_level[gi] & ~w_level[1-gi];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_hold <= '0;
                end else if (w_press[gi]) begin
                    r_hold <= c_RP_W'(1);
                end else if (!w_only) begin
                    r_hold <= '0;
                end else if (r_hold == c_RP_W'(REPEAT_DELAY)) begin
                    r_hold <= c_RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
                end else begin
                    r_hold <= r_hold + c_RP_W'(1);
                end
            end

            assign w_step[gi] = w_only & ~w_press[gi] &
                                (r_hold == c_RP_W'(REPEAT_DELAY));
        end
    endgenerate

    assign w_up     = w_press[c_UP] | w_step[c_UP];
    assign w_dn     = w_press[c_DN] | w_step[c_DN];
    assign w_unused = w_level[c_EN];
`else
    assign w_up     = w_press[c_UP];
    assign w_dn     = w_press[c_DN];
    assign w_unused = (^w_level) ^ (REPEAT_PERIOD > REPEAT_DELAY);
`endif

    logic [4:0] r_let;
    logic [4:0] r_let_out;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_capture;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_let <= 5'd0;
        end else if (w_up && !w_dn) begin
            r_let <= (r_let == c_LET_MAX) ? 5'd0 : r_let + 5'd1;
        end else if (w_dn && !w_up) begin
            r_let <= (r_let == 5'd0) ? c_LET_MAX : r_let - 5'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_let_out <= 5'd0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_let_out <= r_let;
            end
        end
    end

    // Enter pulses arriving in HOLD are dropped rather than queued.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[c_EN]) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (LET_READY) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign LET       = r_let;
    assign LET_OUT   = r_let_out;
    assign LET_VALID = (r_state == ST_HOLD);
    assign BUSY      = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: doc/letter_entry_encoder.md
Name: letter_entry_encoder

Overview:
- Input-side counterpart of the letter display path: converts raw push-button activity into a 5-bit letter code (A = 0 … Z = 25).
- UP/DOWN scroll the current selection with wrap-around. ENTER commits the selection to the downstream cipher path over a valid/ready handshake.
- LET drives the seven-segment letter decoder so the user sees the live selection.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new button level (5 ms at 100 MHz).
- REPEAT_DELAY, 50000000, hold time before the first auto-repeat step (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 15000000, interval between subsequent auto-repeat steps (used only with AUTO_REPEAT_EN).

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- BTN_UP  input  1  raw asynchronous button, active high
- BTN_DOWN  input  1  raw asynchronous button, active high
- BTN_ENTER  input  1  raw asynchronous button, active high
- LET  output  5  live selection, always 0..25
- LET_OUT  output  5  committed letter, stable while LET_VALID is high
- LET_VALID  output  1  committed letter available
- LET_READY  input  1  consumer accepts LET_OUT
- BUSY  output  1  high in HOLD state

Behaviour:
- Reset: one clock (CLK). RST is asynchronous and active-high; it forces the following immediately, regardless of CLK:
  - LET = 0, LET_OUT = 0, LET_VALID = 0, BUSY = 0
  - all synchronizers, debounced levels and counters = 0
  - FSM = IDLE
- Reset mid-operation: an in-flight commit is discarded, no transfer occurs.
- Synchronizer: each button passes through its own 2-flop synchronizer.
- Debounce, per button:
  - The counter increments while the synchronized level differs from the debounced level.
  - The counter clears when the two levels are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- Press pulse: one-cycle pulse on each debounced 0->1 edge.
  - Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Debounced release (1->0) produces nothing.
- Selection update, registered on the cycle after the pulse:
  - up pulse: LET = (LET == 25) ? 0 : LET + 1
  - down pulse: LET = (LET == 0) ? 25 : LET - 1
  - up and down pulses in the same cycle: LET unchanged
  - Values 26..31 are unreachable; arithmetic is 5-bit with explicit wrap at 25/0.
- FSM IDLE:
  - enter pulse -> LET_OUT <= LET, LET_VALID <= 1, BUSY <= 1, go to HOLD
  - If an up/down pulse occurs in the same cycle as enter, LET_OUT captures the pre-update LET.
- FSM HOLD:
  - LET_OUT and LET_VALID held stable until a cycle with LET_VALID & LET_READY.
  - On that transfer cycle: next cycle LET_VALID = 0, BUSY = 0, go to IDLE.
  - Enter pulses in HOLD are dropped, not queued.
  - UP/DOWN still update LET in HOLD; LET_OUT is unaffected.
- LET_READY high while LET_VALID is low has no effect.
- At most one commit per ENTER press; a second commit needs a release, then a new debounced press.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: when exactly one of the UP/DOWN debounced levels stays high, a per-direction hold counter runs.
  - After REPEAT_DELAY cycles (measured from the press pulse), one extra step is generated.
  - Thereafter one extra step every REPEAT_PERIOD cycles.
  - Each step follows the same wrap rules as a press.
  - Release, or both buttons held, clears the counter.
- Undefined: the hold counters are not built; each debounced press yields exactly one step.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset, then 3 clean UP presses -> LET = 3. Each step is registered 2+4+2 cycles after its raw edge. LET_VALID stays 0.
- DOWN from LET=0 -> LET = 25. Then UP -> LET = 0.
- BTN_UP glitches of 1-3 cycles, then a stable press -> exactly one increment. LET goes 7 -> 8.
- LET=12, ENTER with LET_READY=0 for 10 cycles:
  - LET_VALID=1, LET_OUT=12, BUSY=1 throughout.
  - UP in HOLD -> LET=13, LET_OUT=12.
  - LET_READY=1 -> one transfer, LET_VALID=0 next cycle.
- Second ENTER during HOLD -> ignored. Exactly one transfer observed. FSM returns to IDLE.
- Assert RST while in HOLD with LET=5 -> all outputs 0 immediately, without waiting for a CLK edge.
- With AUTO_REPEAT_EN: hold UP for 60 cycles after its press pulse (LET=24 before the press):
  - press step: 24 -> 25
  - auto steps at pulse+20, +28, +36, +44, +52: 0, 1, 2, 3, 4, so LET = 4
  - Without the macro: LET = 25.
